oc_sweep_checker: RTL

//   Exhaustive stimulus/response stage for the 3-input switch-level gate (inputs a,b,c; output w).

---
 rtl/oc_sweep_checker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/oc_sweep_checker.sv
// oc_sweep_checker: exhaustive stimulus/response stage for a 3-input gate.
//   Drives all 8 {a,b,c} vectors, holding each for SETTLE cycles. It checks w on the last
//   cycle of each window against EXP and counts w toggles inside each window.
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   start          sweep request, sampled only while idle
//   w_in           gate output (already synchronous to clk)
//   a, b, c        registered gate inputs; cur_idx mirrors {a,b,c}
//   busy           high for the whole sweep; done is a one-cycle completion pulse
//   pass           1 iff no mismatches and no glitches (valid from done)
//   mismatch_map   bit i set if w differed from EXP[i] at the check of vector i
//   glitch_cnt     saturating count of in-window w changes
module oc_sweep_checker #(
  parameter logic [7:0]  EXP    = 8'h69,
  parameter int unsigned SETTLE = 4,
  parameter bit          GRAY   = 1'b0,
  parameter int unsigned GW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          w_in,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    mismatch_map,
  output logic [GW-1:0] glitch_cnt,
  output logic [2:0]    cur_idx
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

  state_e          state_q;
  logic [2:0]      step_q;
  logic [CntW-1:0] cnt_q;
  logic            w_prev_q;
  logic [2:0]      abc_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [7:0]      mm_q;
  logic [GW-1:0]   gl_q;

  logic            last_cyc;
  logic            glitch_hit;
  logic [7:0]      mm_d;
  logic [GW-1:0]   gl_d;

  function automatic logic [2:0] seq_f(input logic [2:0] s);
    return GRAY ? (s ^ (s >> 1)) : s;
  endfunction

  // Window bookkeeping, evaluated only while holding a vector.
  always_comb begin
    last_cyc   = (cnt_q == CntW'(SETTLE - 1));
    // Cycle 0 of a window only captures w_prev; the vector just changed so w may move.
    glitch_hit = (state_q == StHold) && (cnt_q != '0) && (w_in != w_prev_q);
    gl_d       = gl_q;
    if (glitch_hit && !(&gl_q)) begin
      gl_d = gl_q + GW'(1);
    end
    mm_d = mm_q;
    if ((state_q == StHold) && last_cyc) begin
      mm_d[abc_q] = (w_in != EXP[abc_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      step_q   <= '0;
      cnt_q    <= '0;
      w_prev_q <= 1'b0;
      abc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      mm_q     <= '0;
      gl_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            mm_q    <= '0;
            gl_q    <= '0;
            pass_q  <= 1'b0;
            step_q  <= '0;
            abc_q   <= seq_f(3'd0);
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StHold;
          end
        end
        StHold: begin
          w_prev_q <= w_in;
          gl_q     <= gl_d;
          mm_q     <= mm_d;
          if (last_cyc) begin
            cnt_q <= '0;
            if (step_q != 3'd7) begin
              step_q <= step_q + 3'd1;
              abc_q  <= seq_f(step_q + 3'd1);
            end else begin
              // Pass uses the next-state values so the final check is included.
              state_q <= StDone;
              done_q  <= 1'b1;
              pass_q  <= (mm_d == '0) && (gl_d == '0);
              busy_q  <= 1'b0;
              abc_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a            = abc_q[2];
  assign b            = abc_q[1];
  assign c            = abc_q[0];
  assign cur_idx      = abc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_map = mm_q;
  assign glitch_cnt   = gl_q;

endmodule
